// File: rtl/ctx_switch_ctrl_if.sv
// Command and MMU-control bundle for ctx_switch_ctrl.
// master = CPU control path side, slave = the sequencer.
interface ctx_switch_ctrl_if #(
    parameter int unsigned PID_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [PID_W-1:0] cmd_pid;
    logic [31:0]      cmd_base;
    logic             mmu_we_sel;
    logic [31:0]      mmu_sel;
    logic             mmu_we_addr;
    logic [31:0]      mmu_offset;
    logic             mmu_user_mode;
    logic             mmu_kernel_mode;
    logic [PID_W-1:0] cur_pid;
    logic             user_active;
    logic             busy;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_pid, cmd_base,
        input  cmd_ready, mmu_we_sel, mmu_sel, mmu_we_addr, mmu_offset,
        input  mmu_user_mode, mmu_kernel_mode, cur_pid, user_active, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_pid, cmd_base,
        output cmd_ready, mmu_we_sel, mmu_sel, mmu_we_addr, mmu_offset,
        output mmu_user_mode, mmu_kernel_mode, cur_pid, user_active, busy, err
    );
endinterface

// File: rtl/ctx_switch_ctrl.sv
// Context-switch sequencer driving the I-side MMU selector/offset/mode strobes.
// Optional CTX_SHADOW_CHECK_EN: reject ENTER_USER to a slot never given a base.
module ctx_switch_ctrl #(
    parameter int unsigned NPROC = 11,
    parameter int unsigned PID_W = 4
) (
    input logic                clk,
    input logic                reset,
    ctx_switch_ctrl_if.slave   bus_io
);
    localparam logic [1:0] OpSetBase     = 2'b00;
    localparam logic [1:0] OpEnterUser   = 2'b01;
    localparam logic [1:0] OpEnterKernel = 2'b10;

    typedef enum logic [2:0] {
        StRstKern, StIdle, StSel, StOfs, StMode, StSettle
    } state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [PID_W-1:0] pid_q;
    logic [31:0]      base_q;
    logic             we_sel_q;
    logic             we_addr_q;
    logic             user_mode_q;
    logic             kernel_mode_q;
    logic [PID_W-1:0] sel_q;
    logic [31:0]      offset_q;
    logic [PID_W-1:0] cur_pid_q;
    logic             user_q;
    logic             err_q;
    logic             cmd_bad;

`ifdef CTX_SHADOW_CHECK_EN
    logic [NPROC-1:0] valid_q;
`endif

    always_comb begin
        cmd_bad = 1'b0;
        if (bus_io.cmd_op == 2'b11) begin
            cmd_bad = 1'b1;
        end else if (bus_io.cmd_op != OpEnterKernel && 32'(bus_io.cmd_pid) >= NPROC) begin
            cmd_bad = 1'b1;
        end
`ifdef CTX_SHADOW_CHECK_EN
        else if (bus_io.cmd_op == OpEnterUser && !valid_q[bus_io.cmd_pid]) begin
            cmd_bad = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRstKern;
            op_q          <= 2'b00;
            pid_q         <= '0;
            base_q        <= '0;
            we_sel_q      <= 1'b0;
            we_addr_q     <= 1'b0;
            user_mode_q   <= 1'b0;
            kernel_mode_q <= 1'b0;
            sel_q         <= '0;
            offset_q      <= '0;
            cur_pid_q     <= '0;
            user_q        <= 1'b0;
            err_q         <= 1'b0;
`ifdef CTX_SHADOW_CHECK_EN
            valid_q       <= '0;
`endif
        end else begin
            we_sel_q      <= 1'b0;
            we_addr_q     <= 1'b0;
            user_mode_q   <= 1'b0;
            kernel_mode_q <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                // MMU mode register has no reset: hold off ready until the kernel pulse is out
                StRstKern: begin
                    if (!kernel_mode_q) kernel_mode_q <= 1'b1;
                    else                state_q       <= StIdle;
                end
                StIdle: begin
                    if (bus_io.cmd_valid) begin
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            op_q   <= bus_io.cmd_op;
                            pid_q  <= bus_io.cmd_pid;
                            base_q <= bus_io.cmd_base;
                            if (bus_io.cmd_op == OpEnterKernel) begin
                                kernel_mode_q <= 1'b1;
                                state_q       <= StMode;
                            end else begin
                                we_sel_q <= 1'b1;
                                sel_q    <= bus_io.cmd_pid;
                                state_q  <= StSel;
                            end
                        end
                    end
                end
                StSel: begin
                    if (op_q == OpSetBase) begin
                        we_addr_q <= 1'b1;
                        offset_q  <= base_q;
                        state_q   <= StOfs;
                    end else begin
                        user_mode_q <= 1'b1;
                        state_q     <= StMode;
                    end
                end
                StOfs: begin
`ifdef CTX_SHADOW_CHECK_EN
                    valid_q[pid_q] <= 1'b1;
`endif
                    state_q <= StIdle;
                end
                StMode: begin
                    if (op_q == OpEnterUser) begin
                        cur_pid_q <= pid_q;
                        user_q    <= 1'b1;
                    end else begin
                        cur_pid_q <= '0;
                        user_q    <= 1'b0;
                    end
                    state_q <= StSettle;
                end
                StSettle: state_q <= StIdle;
                default:  state_q <= StRstKern;
            endcase
        end
    end

    assign bus_io.cmd_ready       = (state_q == StIdle);
    assign bus_io.busy            = (state_q != StIdle);
    assign bus_io.mmu_we_sel      = we_sel_q;
    assign bus_io.mmu_sel         = {{(32 - PID_W){1'b0}}, sel_q};
    assign bus_io.mmu_we_addr     = we_addr_q;
    assign bus_io.mmu_offset      = offset_q;
    assign bus_io.mmu_user_mode   = user_mode_q;
    assign bus_io.mmu_kernel_mode = kernel_mode_q;
    assign bus_io.cur_pid         = cur_pid_q;
    assign bus_io.user_active     = user_q;
    assign bus_io.err             = err_q;
endmodule

// File: tb/tb_ctx_switch_ctrl.sv
// Directed bench for ctx_switch_ctrl; inputs driven and outputs sampled 1ns after posedge.
module tb_ctx_switch_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    ctx_switch_ctrl_if #(.PID_W(4)) bus ();

    ctx_switch_ctrl #(.NPROC(11), .PID_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command for a single cycle; returns in cycle N+1.
    task automatic issue(input logic [1:0] op, input logic [3:0] pid, input logic [31:0] base);
        bus.cmd_op    = op;
        bus.cmd_pid   = pid;
        bus.cmd_base  = base;
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic chk_no_strobes(input string tag);
        chk({tag, "_we_sel"}, 32'(bus.mmu_we_sel), 0);
        chk({tag, "_we_addr"}, 32'(bus.mmu_we_addr), 0);
        chk({tag, "_user"}, 32'(bus.mmu_user_mode), 0);
        chk({tag, "_kern"}, 32'(bus.mmu_kernel_mode), 0);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_pid   = 4'd0;
        bus.cmd_base  = 32'd0;
        tick();
        tick();
        tick();

        // Reset state
        chk("rst_busy", 32'(bus.busy), 1);
        chk("rst_ready", 32'(bus.cmd_ready), 0);
        chk_no_strobes("rst");
        chk("rst_sel", bus.mmu_sel, 0);
        chk("rst_ofs", bus.mmu_offset, 0);
        chk("rst_cur", 32'(bus.cur_pid), 0);
        chk("rst_user", 32'(bus.user_active), 0);
        chk("rst_err", 32'(bus.err), 0);

        // Release: one kernel pulse, then ready
        reset = 1'b0;
        tick();
        chk("rk_kern", 32'(bus.mmu_kernel_mode), 1);
        chk("rk_ready", 32'(bus.cmd_ready), 0);
        tick();
        chk("rk_kern_drop", 32'(bus.mmu_kernel_mode), 0);
        chk("rk_ready_up", 32'(bus.cmd_ready), 1);
        chk("rk_busy", 32'(bus.busy), 0);

        // SET_BASE pid 3, base 0x400
        issue(2'b00, 4'd3, 32'h0000_0400);
        chk("sb_we_sel", 32'(bus.mmu_we_sel), 1);
        chk("sb_sel", bus.mmu_sel, 3);
        chk("sb_we_addr0", 32'(bus.mmu_we_addr), 0);
        chk("sb_busy1", 32'(bus.busy), 1);
        tick();
        chk("sb_we_addr", 32'(bus.mmu_we_addr), 1);
        chk("sb_ofs", bus.mmu_offset, 32'h400);
        chk("sb_we_sel_drop", 32'(bus.mmu_we_sel), 0);
        chk("sb_busy2", 32'(bus.busy), 1);
        tick();
        chk("sb_ready", 32'(bus.cmd_ready), 1);
        chk_no_strobes("sb_done");
        chk("sb_sel_hold", bus.mmu_sel, 3);
        chk("sb_ofs_hold", bus.mmu_offset, 32'h400);

        // ENTER_USER pid 3
        issue(2'b01, 4'd3, 32'd0);
        chk("eu_we_sel", 32'(bus.mmu_we_sel), 1);
        chk("eu_sel", bus.mmu_sel, 3);
        tick();
        chk("eu_user_pulse", 32'(bus.mmu_user_mode), 1);
        chk("eu_we_sel_drop", 32'(bus.mmu_we_sel), 0);
        chk("eu_busy2", 32'(bus.busy), 1);
        tick();
        chk("eu_cur", 32'(bus.cur_pid), 3);
        chk("eu_active", 32'(bus.user_active), 1);
        chk("eu_busy3", 32'(bus.busy), 1);
        chk_no_strobes("eu_settle");
        tick();
        chk("eu_idle", 32'(bus.busy), 0);

        // ENTER_KERNEL
        issue(2'b10, 4'd0, 32'd0);
        chk("ek_kern", 32'(bus.mmu_kernel_mode), 1);
        chk("ek_we_sel", 32'(bus.mmu_we_sel), 0);
        chk("ek_busy1", 32'(bus.busy), 1);
        tick();
        chk("ek_cur", 32'(bus.cur_pid), 0);
        chk("ek_active", 32'(bus.user_active), 0);
        chk("ek_busy2", 32'(bus.busy), 1);
        tick();
        chk("ek_idle", 32'(bus.busy), 0);

        // Rejections: pid out of range, reserved op
        issue(2'b01, 4'd12, 32'd0);
        chk("rj_pid_err", 32'(bus.err), 1);
        chk("rj_pid_busy", 32'(bus.busy), 0);
        chk("rj_pid_ready", 32'(bus.cmd_ready), 1);
        chk_no_strobes("rj_pid");
        tick();
        chk("rj_err_drop", 32'(bus.err), 0);
        issue(2'b11, 4'd1, 32'd0);
        chk("rj_op_err", 32'(bus.err), 1);
        chk("rj_op_busy", 32'(bus.busy), 0);
        chk_no_strobes("rj_op");
        tick();

        // ENTER_USER to never-programmed pid 5
        issue(2'b01, 4'd5, 32'd0);
`ifdef CTX_SHADOW_CHECK_EN
        chk("u5_err", 32'(bus.err), 1);
        chk("u5_busy", 32'(bus.busy), 0);
        chk_no_strobes("u5");
        tick();
`else
        chk("u5_err", 32'(bus.err), 0);
        chk("u5_we_sel", 32'(bus.mmu_we_sel), 1);
        chk("u5_sel", bus.mmu_sel, 5);
        tick();
        tick();
        chk("u5_cur", 32'(bus.cur_pid), 5);
        tick();
        chk("u5_idle", 32'(bus.busy), 0);
`endif

        // Command held while busy is accepted only once ready
        issue(2'b00, 4'd2, 32'h0000_0800);
        tick();
        bus.cmd_op    = 2'b10;
        bus.cmd_valid = 1'b1;
        chk("hold_ofs", 32'(bus.mmu_we_addr), 1);
        tick();
        chk("hold_ready", 32'(bus.cmd_ready), 1);
        chk("hold_no_kern", 32'(bus.mmu_kernel_mode), 0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("hold_kern", 32'(bus.mmu_kernel_mode), 1);
        tick();
        tick();
        chk("hold_idle", 32'(bus.busy), 0);

        // Reset during OFS of SET_BASE pid 7
        issue(2'b00, 4'd7, 32'h0000_0abc);
        tick();
        chk("mr_ofs", 32'(bus.mmu_we_addr), 1);
        reset = 1'b1;
        tick();
        chk_no_strobes("mr");
        chk("mr_busy", 32'(bus.busy), 1);
        chk("mr_ofs_rst", bus.mmu_offset, 0);
        reset = 1'b0;
        tick();
        chk("mr_kern", 32'(bus.mmu_kernel_mode), 1);
        tick();
        chk("mr_ready", 32'(bus.cmd_ready), 1);
        issue(2'b01, 4'd7, 32'd0);
`ifdef CTX_SHADOW_CHECK_EN
        chk("mr_valid_clear", 32'(bus.err), 1);
        chk("mr_no_sel", 32'(bus.mmu_we_sel), 0);
`else
        chk("mr_eu_err", 32'(bus.err), 0);
        chk("mr_eu_sel", 32'(bus.mmu_we_sel), 1);
`endif
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
